wb_regfile: RTL and testbench

Write-back stage plus architectural register file for the 5-stage MIPS pipeline. It sits directly downstream of the MEM/WB pipeline register and consumes its WB_* outputs. It selects the write-back value, sizes halfword loads, and commits the result to a 32x32 register file. The same register file serves the ID stage's two read ports, with a same-cycle write-to-read bypass.

---
 rtl/wb_regfile_pkg.sv | 15 +
 rtl/wb_select.sv | 25 ++
 rtl/wb_regfile.sv | 82 ++++++++
 tb/tb_wb_regfile.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Pipeline defines shared by MEM/WB, the control unit and the write-back stage.
package wb_regfile_pkg;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM  = 2'b01;
  localparam logic [1:0] MEMTOREG_LINK = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Sign-extend the low halfword of a load result to 32 bits.
  function automatic logic [31:0] sext_half(input logic [31:0] word);
    return {{16{word[15]}}, word[15:0]};
  endfunction

endpackage

// File: rtl/wb_select.sv
// Write-back source mux: ALU result, (halfword-sized) load data or link address.
module wb_select
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        mem_to_reg,
  input  logic              halfbyte,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc_add_result,
  output logic [DATA_W-1:0] write_data_c
);

  // The reserved select value 2'b11 falls through to the ALU result.
  always_comb begin
    write_data_c = alu_result;
    case (mem_to_reg)
      MEMTOREG_MEM:  write_data_c = halfbyte ? sext_half(read_data) : read_data;
      MEMTOREG_LINK: write_data_c = pc_add_result;
      default:       write_data_c = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32x32 architectural register file with two ID read
// ports, same-cycle write-to-read bypass and a committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WB_RegWrite,
  input  logic [1:0]        WB_MemToReg,
  input  logic              WB_halfbyte,
  input  logic [DATA_W-1:0] WB_Read,
  input  logic [DATA_W-1:0] WB_ALUResult,
  input  logic [DATA_W-1:0] WB_PCAddResult,
  input  logic [ADDR_W-1:0] WB_RegDst,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] WriteCount
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] write_count_q;
  logic [DATA_W-1:0] write_count_d;
  logic              commit_c;

  wb_select #(.DATA_W(DATA_W)) u_wb_select (
    .mem_to_reg    (WB_MemToReg),
    .halfbyte      (WB_halfbyte),
    .read_data     (WB_Read),
    .alu_result    (WB_ALUResult),
    .pc_add_result (WB_PCAddResult),
    .write_data_c  (WriteData)
  );

  // Writes to $0 are dropped and reset suppresses both the write and the bypass.
  assign commit_c = WB_RegWrite && (WB_RegDst != ADDR_W'(REG_ZERO)) && !Reset;

  always_comb begin
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (commit_c) begin
      regs_d[WB_RegDst] = WriteData;
      write_count_d     = write_count_q + DATA_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      write_count_q <= '0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  always_comb begin
    ReadData1 = '0;
    if (ReadRegister1 != ADDR_W'(REG_ZERO)) begin
      if (commit_c && (ReadRegister1 == WB_RegDst)) ReadData1 = WriteData;
      else                                          ReadData1 = regs_q[ReadRegister1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (ReadRegister2 != ADDR_W'(REG_ZERO)) begin
      if (commit_c && (ReadRegister2 == WB_RegDst)) ReadData2 = WriteData;
      else                                          ReadData2 = regs_q[ReadRegister2];
    end
  end

  assign WriteCount = write_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed cases plus random traffic against an array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        rw;
  logic [1:0]  m2r;
  logic        hb;
  logic [31:0] rdv, alu, pc;
  logic [4:0]  dst, r1, r2;
  logic [31:0] rd1, rd2, wd, wcnt;

  logic [31:0] ref_regs [32];
  logic [31:0] ref_count;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .Clk            (clk),
    .Reset          (rst),
    .WB_RegWrite    (rw),
    .WB_MemToReg    (m2r),
    .WB_halfbyte    (hb),
    .WB_Read        (rdv),
    .WB_ALUResult   (alu),
    .WB_PCAddResult (pc),
    .WB_RegDst      (dst),
    .ReadRegister1  (r1),
    .ReadRegister2  (r2),
    .ReadData1      (rd1),
    .ReadData2      (rd2),
    .WriteData      (wd),
    .WriteCount     (wcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_wd();
    if (m2r == 2'd1) return hb ? {{16{rdv[15]}}, rdv[15:0]} : rdv;
    if (m2r == 2'd2) return pc;
    return alu;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] idx, input logic [31:0] w, input bit commit);
    if (idx == 5'd0) return 32'h0;
    if (commit && idx == dst) return w;
    return ref_regs[idx];
  endfunction

  task automatic drive(input bit i_rst, input bit i_rw, input logic [1:0] i_m2r, input bit i_hb,
                       input logic [31:0] i_rdv, input logic [31:0] i_alu, input logic [31:0] i_pc,
                       input logic [4:0] i_dst, input logic [4:0] i_r1, input logic [4:0] i_r2);
    rst = i_rst; rw = i_rw; m2r = i_m2r; hb = i_hb; rdv = i_rdv;
    alu = i_alu; pc = i_pc; dst = i_dst; r1 = i_r1; r2 = i_r2;
  endtask

  // Check combinational outputs mid-cycle, then advance the model across the edge.
  task automatic step(input string tag);
    logic [31:0] w;
    bit commit;
    @(negedge clk);
    w      = model_wd();
    commit = rw && (dst != 5'd0) && !rst;
    chk({tag, ".wd"},  wd,   w);
    chk({tag, ".rd1"}, rd1,  model_rd(r1, w, commit));
    chk({tag, ".rd2"}, rd2,  model_rd(r2, w, commit));
    chk({tag, ".cnt"}, wcnt, ref_count);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
      ref_count = 32'h0;
    end else if (commit) begin
      ref_regs[dst] = w;
      ref_count     = ref_count + 32'd1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    ref_count = 32'h0;
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    step("rst");

    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 2'd0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0);
      step("rst_read");
    end

    drive(0, 1, 2'd0, 0, 0, 32'h12345678, 0, 5'd8, 5'd8, 5'd0);
    step("alu_byp");
    drive(0, 0, 2'd0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8);
    step("alu_hold");
    chk("cnt_one", wcnt, 32'd1);

    drive(0, 1, 2'd1, 1, 32'hABCD8001, 0, 0, 5'd9, 5'd9, 5'd8);
    step("half_neg");
    chk("half_neg_wd", wd, 32'hFFFF8001);
    drive(0, 1, 2'd1, 1, 32'h00007FFF, 0, 0, 5'd10, 5'd9, 5'd10);
    step("half_pos");
    drive(0, 1, 2'd1, 0, 32'hABCD7FFF, 0, 0, 5'd11, 5'd10, 5'd11);
    step("word_ld");
    drive(0, 1, 2'd2, 1, 32'hDEADBEEF, 32'h1, 32'h00400024, 5'd31, 5'd11, 5'd31);
    step("link");
    drive(0, 1, 2'd3, 1, 32'hDEADBEEF, 32'h5, 32'h00400024, 5'd12, 5'd31, 5'd12);
    step("rsvd");
    chk("rsvd_wd", wd, 32'h5);
    drive(0, 1, 2'd0, 0, 0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 5'd12);
    step("zero_wr");
    drive(0, 0, 2'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd9);
    step("zero_rd");

    drive(0, 1, 2'd0, 0, 0, 32'h00000042, 0, 5'd4, 5'd4, 5'd4);
    step("pre4");
    drive(1, 1, 2'd0, 0, 0, 32'h00000077, 0, 5'd4, 5'd4, 5'd9);
    step("rst_wr");
    drive(0, 0, 2'd0, 0, 0, 0, 0, 5'd4, 5'd4, 5'd9);
    step("post_rst");
    chk("post_rst_cnt", wcnt, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, d,
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31)));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
